// File: rtl/regmem_pkg.sv
// regmem_pkg: shared types and helpers for the reg_memory_be data memory.
//   regmem_state_e : sweep sequencer states (CLEAR, READY)
//   BYTES_PER_WORD : bytes in one data word of the default configuration
//   INDEX_BITS     : word-index width of the default configuration
//   merge()        : per-byte select between old and new data under a byte enable
package regmem_pkg;

  localparam int DEF_DATA_BIT_WIDTH = 32;
  localparam int DEF_DMEMADDRBITS   = 8;
  localparam int DEF_DMEMWORDBITS   = 2;

  localparam int BYTES_PER_WORD = DEF_DATA_BIT_WIDTH / 8;
  localparam int INDEX_BITS     = DEF_DMEMADDRBITS - DEF_DMEMWORDBITS;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } regmem_state_e;

  // Byte merge: the enabled byte takes the new value, otherwise the old one stays.
  function automatic logic [7:0] merge(input logic [7:0] old_byte,
                                       input logic [7:0] new_byte,
                                       input logic       be);
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/regmem_clear_seq.sv
// regmem_clear_seq: post-reset zeroing sweep for reg_memory_be.
// After every reset it walks word indices 0..DMEMWORDS-1, one per cycle, asking
// the top level to write zero there, then settles in READY.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   o_clr_we       : sweep write strobe (high for exactly DMEMWORDS cycles)
//   o_clr_idx      : word index being cleared
//   o_init_busy    : sweep in progress
//   o_ready        : sweep finished, memory may accept requests
//   o_state        : current state, for observation
module regmem_clear_seq
  import regmem_pkg::*;
#(
  parameter int DMEMWORDS = 64,
  parameter int CNT_BITS  = 6
) (
  input  logic                clk,
  input  logic                reset,
  output logic                o_clr_we,
  output logic [CNT_BITS-1:0] o_clr_idx,
  output logic                o_init_busy,
  output logic                o_ready,
  output regmem_state_e       o_state
);

  regmem_state_e       r_state;
  logic [CNT_BITS-1:0] r_cnt;
  logic                r_busy;
  logic                r_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_cnt == CNT_BITS'(DMEMWORDS - 1)) begin
            r_state <= READY;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_BITS'(1);
          end
        end
        READY: begin
          r_state <= READY;
        end
        default: begin
          r_state <= CLEAR;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // The sweep writes on every cycle it is busy, so the strobe is the busy flag.
  assign o_clr_we    = r_busy;
  assign o_clr_idx   = r_cnt;
  assign o_init_busy = r_busy;
  assign o_ready     = r_ready;
  assign o_state     = r_state;

endmodule

// File: rtl/reg_memory_be.sv
// reg_memory_be: byte-addressed data memory with per-byte write enables,
// a valid/ready request port and a fixed two-edge load latency.
// Contents are zeroed by a hardware sweep after every reset.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   req_valid/req_ready     : request handshake
//   req_we, req_addr        : 1=store / 0=load, byte address
//   req_wdata, req_be       : store data, byte enables (bit k covers byte k)
//   rsp_valid, rsp_rdata    : one-cycle load response, data holds between pulses
//   rsp_err                 : out-of-range flag, qualified by rsp_valid
//   init_busy               : clear sweep in progress
//   dbg_state               : sweep sequencer state, for observation
// Optional feature macro: REGMEM_BOUNDS_CHECK_EN
//   defined   : out-of-range requests are flagged with rsp_err, stores suppressed
//   undefined : upper address bits ignored, index wraps modulo DMEMWORDS
//               (DMEMWORDS must then be a power of two), rsp_err is always 0
//
// Handshake: a request transfers on the rising edge where req_valid && req_ready
// are both high; there is no response backpressure, rsp_* is a one-cycle pulse.
module reg_memory_be
  import regmem_pkg::*;
#(
  parameter int DATA_BIT_WIDTH = 8 * BYTES_PER_WORD,
  parameter int DMEMWORDBITS   = $clog2(BYTES_PER_WORD),
  parameter int DMEMADDRBITS   = INDEX_BITS + $clog2(BYTES_PER_WORD),
  parameter int DMEMWORDS      = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [DATA_BIT_WIDTH-1:0]   req_addr,
  input  logic [DATA_BIT_WIDTH-1:0]   req_wdata,
  input  logic [DATA_BIT_WIDTH/8-1:0] req_be,
  output logic                        rsp_valid,
  output logic [DATA_BIT_WIDTH-1:0]   rsp_rdata,
  output logic                        rsp_err,
  output logic                        init_busy,
  output regmem_state_e               dbg_state
);

  localparam int BPW  = DATA_BIT_WIDTH / 8;
  localparam int IDXW = DMEMADDRBITS - DMEMWORDBITS;
  localparam int MEMW = (DMEMWORDS > 1) ? $clog2(DMEMWORDS) : 1;

  // Sweep sequencer
  logic            w_clr_we;
  logic [MEMW-1:0] w_clr_idx;
  logic            w_ready;

  regmem_clear_seq #(
    .DMEMWORDS (DMEMWORDS),
    .CNT_BITS  (MEMW)
  ) u_clear_seq (
    .clk         (clk),
    .reset       (reset),
    .o_clr_we    (w_clr_we),
    .o_clr_idx   (w_clr_idx),
    .o_init_busy (init_busy),
    .o_ready     (w_ready),
    .o_state     (dbg_state)
  );

  assign req_ready = w_ready;

  // Request decode
  logic            w_accept;
  logic [IDXW-1:0] w_full_idx;
  logic [MEMW-1:0] w_req_idx;
  logic            w_req_err;
  logic            w_unused;

  assign w_accept   = req_valid && req_ready;
  assign w_full_idx = req_addr[DMEMADDRBITS-1:DMEMWORDBITS];
  // Low index bits select the word; without bounds checking this is the wrap.
  assign w_req_idx  = w_full_idx[MEMW-1:0];
  // Byte-offset bits (and, by default, the upper bits) carry no meaning here.
  assign w_unused   = ^req_addr;

`ifdef REGMEM_BOUNDS_CHECK_EN
  assign w_req_err = (|req_addr[DATA_BIT_WIDTH-1:DMEMADDRBITS]) ||
                     (32'(w_full_idx) >= 32'(DMEMWORDS));
`else
  assign w_req_err = 1'b0;
`endif

  // Stage 1: capture the accepted request
  logic                      r_s1_valid;
  logic                      r_s1_we;
  logic                      r_s1_err;
  logic [MEMW-1:0]           r_s1_idx;
  logic [BPW-1:0]            r_s1_be;
  logic [DATA_BIT_WIDTH-1:0] r_s1_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_we    <= req_we;
      r_s1_err   <= w_req_err;
      r_s1_idx   <= w_req_idx;
      r_s1_be    <= req_be;
      r_s1_wdata <= req_wdata;
    end
  end

  // Stage 2: memory array, commit of stores, read of loads
  logic [DATA_BIT_WIDTH-1:0] r_mem [DMEMWORDS];
  logic [DATA_BIT_WIDTH-1:0] w_merged;
  logic                      w_commit;

  always_comb begin
    w_merged = r_mem[r_s1_idx];
    for (int k = 0; k < BPW; k++) begin
      w_merged[8*k +: 8] = merge(r_mem[r_s1_idx][8*k +: 8], r_s1_wdata[8*k +: 8], r_s1_be[k]);
    end
  end

  // Reset on the commit edge cancels an in-flight store.
  assign w_commit = r_s1_valid && r_s1_we && !r_s1_err && !reset;

  // The sweep and stage 2 never overlap: requests are refused while sweeping.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_commit) begin
      r_mem[r_s1_idx] <= w_merged;
    end
  end

  logic                      r_rsp_valid;
  logic                      r_rsp_err;
  logic [DATA_BIT_WIDTH-1:0] r_rsp_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      // Loads always respond; stores respond only when rejected as out of range.
      r_rsp_valid <= r_s1_valid && (!r_s1_we || r_s1_err);
      r_rsp_err   <= r_s1_valid && r_s1_err;
      if (r_s1_valid && !r_s1_we) begin
        r_rsp_rdata <= r_s1_err ? '0 : r_mem[r_s1_idx];
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_reg_memory_be.sv
module tb_reg_memory_be;
  import regmem_pkg::*;

  localparam int NW = 16;

  // Clock / reset / DUT
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic [3:0]    req_be = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          init_busy;
  regmem_state_e dbg_state;

  always #5 clk = ~clk;

  reg_memory_be #(
    .DATA_BIT_WIDTH (32),
    .DMEMWORDBITS   (2),
    .DMEMADDRBITS   (8),
    .DMEMWORDS      (NW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_busy (init_busy),
    .dbg_state (dbg_state)
  );

  // Scoreboard counters
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a request accepted on one edge takes effect on the next,
  // unless reset is high on that next edge.
  typedef struct {
    bit          we;
    int          idx;
    bit          err;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  logic [31:0] m_mem [NW];
  req_t        m_q[$];
  int          m_busy_left = 0;
  bit          m_live = 0;
  bit          m_ready = 0;
  bit          m_busy = 1;
  bit          m_rsp_valid = 0;
  bit          m_rsp_err = 0;
  logic [31:0] m_rsp_rdata = '0;

  function automatic void decode(input logic [31:0] addr, output int idx, output bit err);
    int word;
    word = int'((addr >> 2) & 32'h3F);
`ifdef REGMEM_BOUNDS_CHECK_EN
    err = ((addr >> 8) != 0) || (word >= NW);
    idx = err ? 0 : word;
`else
    err = 1'b0;
    idx = word % NW;
`endif
  endfunction

  always @(posedge clk) begin
    req_t r;
    bit   acc;
    int   idx;
    bit   err;
    acc = req_valid && m_ready;
    if (reset) begin
      m_live      = 1;
      m_q.delete();
      m_ready     = 0;
      m_busy      = 1;
      m_busy_left = NW;
      m_rsp_valid = 0;
      m_rsp_err   = 0;
      m_rsp_rdata = '0;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else begin
      m_rsp_valid = 0;
      m_rsp_err   = 0;
      if (m_q.size() > 0) begin
        r = m_q.pop_front();
        if (r.err) begin
          m_rsp_valid = 1;
          m_rsp_err   = 1;
          if (!r.we) m_rsp_rdata = '0;
        end else if (r.we) begin
          for (int k = 0; k < 4; k++)
            if (r.be[k]) m_mem[r.idx][8*k +: 8] = r.wdata[8*k +: 8];
        end else begin
          m_rsp_valid = 1;
          m_rsp_rdata = m_mem[r.idx];
        end
      end
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) begin
          m_busy  = 0;
          m_ready = 1;
        end
      end
      if (acc) begin
        decode(req_addr, idx, err);
        r.we = req_we; r.idx = idx; r.err = err; r.wdata = req_wdata; r.be = req_be;
        m_q.push_back(r);
      end
    end
  end

  // Compare process: every cycle once the model has seen reset
  always @(negedge clk) begin
    if (m_live) begin
      chk("init_busy", 32'(init_busy), 32'(m_busy));
      chk("req_ready", 32'(req_ready), 32'(m_ready));
      chk("dbg_state", 32'(dbg_state == READY), 32'(m_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
      chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
      if (m_rsp_valid) chk("rsp_err", 32'(rsp_err), 32'(m_rsp_err));
    end
  end

  // Driver tasks
  task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Latency counts negedges after the acceptance edge; 0 means no response.
  task automatic wait_rsp(output logic [31:0] d, output logic e, output int lat);
    bit found;
    found = 0;
    d = '0; e = 1'b0; lat = 0;
    for (int i = 1; i <= 10 && !found; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        found = 1;
        lat = i;
        d = rsp_rdata;
        e = rsp_err;
      end
    end
  endtask

  task automatic measure_busy(output int n, output int seen);
    n = 0; seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
      if (!init_busy) break;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat, nb, ns, pulses, run, best_run;

    // 1: reset release, sweep length, cleared contents
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    measure_busy(nb, ns);
    chk("t1_busy_cycles", nb, 16);
    chk("t1_ready_after_sweep", 32'(req_ready), 1);
    issue(0, 32'h3C, '0, '0);
    wait_rsp(d, e, lat);
    chk("t1_load_3c", d, 32'h0);
    chk("t1_load_latency", lat, 2);

    // 2: full-word store then load
    issue(1, 32'h10, 32'hDEADBEEF, 4'hF);
    issue(0, 32'h10, '0, '0);
    wait_rsp(d, e, lat);
    chk("t2_load_10", d, 32'hDEADBEEF);
    chk("t2_latency", lat, 2);

    // 3: partial-byte store
    issue(1, 32'h10, 32'h11223344, 4'b0101);
    issue(0, 32'h13, '0, '0);
    wait_rsp(d, e, lat);
    chk("t3_byte_merge", d, 32'hDE22BE44);

    // 4: store-then-load forwarding by ordering, then a burst of loads
    issue(1, 32'h20, 32'hA5A5A5A5, 4'hF);
    issue(0, 32'h20, '0, '0);
    wait_rsp(d, e, lat);
    chk("t4_store_load_b2b", d, 32'hA5A5A5A5);
    chk("t4_b2b_latency", lat, 2);
    issue(1, 32'h24, 32'h01020304, 4'h0);
    idle(3);
    pulses = 0; run = 0; best_run = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) issue(0, 32'(i * 4), '0, '0);
      end
      begin
        repeat (12) begin
          @(negedge clk);
          if (rsp_valid) begin
            pulses++;
            run++;
            if (run > best_run) best_run = run;
          end else begin
            run = 0;
          end
        end
      end
    join
    chk("t4_burst_pulses", pulses, 8);
    chk("t4_burst_consecutive", best_run, 8);
    issue(0, 32'h24, '0, '0);
    wait_rsp(d, e, lat);
    chk("t4_be0_store_no_change", d, 32'h0);

    // 6: address 0x100
    issue(1, 32'h100, 32'hCAFEF00D, 4'hF);
`ifdef REGMEM_BOUNDS_CHECK_EN
    wait_rsp(d, e, lat);
    chk("t6_store_err_pulse", 32'(e), 1);
`endif
    issue(0, 32'h100, '0, '0);
    wait_rsp(d, e, lat);
`ifdef REGMEM_BOUNDS_CHECK_EN
    chk("t6_load_100_data", d, 32'h0);
    chk("t6_load_100_err", 32'(e), 1);
`else
    chk("t6_load_100_alias", d, 32'hCAFEF00D);
    chk("t6_load_100_err", 32'(e), 0);
`endif
    issue(0, 32'h0, '0, '0);
    wait_rsp(d, e, lat);
`ifdef REGMEM_BOUNDS_CHECK_EN
    chk("t6_word0_unchanged", d, 32'h0);
`else
    chk("t6_word0_aliased", d, 32'hCAFEF00D);
`endif
    chk("t6_word0_err", 32'(e), 0);

    // Randomized traffic checked by the model
    for (int i = 0; i < 400; i++) begin
      int          sel;
      logic [31:0] a;
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        sel = $urandom_range(0, 7);
        if (sel < 6)       a = 32'($urandom_range(0, 63));
        else if (sel == 6) a = 32'($urandom_range(0, 255));
        else               a = $urandom;
        issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      end
    end
    idle(4);

    // 5: reset partway through the sweep restarts it
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    measure_busy(nb, ns);
    chk("t5_busy_after_mid_reset", nb, 16);

    // 5: reset with a load in flight produces no response
    issue(1, 32'h30, 32'h5A5A5A5A, 4'hF);
    issue(0, 32'h30, '0, '0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    measure_busy(nb, ns);
    chk("t5_no_rsp_after_reset", ns, 0);
    chk("t5_busy_again", nb, 16);
    chk("t5_rdata_reset", rsp_rdata, 32'h0);
    issue(0, 32'h30, '0, '0);
    wait_rsp(d, e, lat);
    chk("t5_cleared_after_reset", d, 32'h0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
